// File: rtl/tdp_ram_param.sv
// True dual-port RAM: byte enables, per-port same-address write modes, optional zero-fill after reset.
// Define TDP_RAM_PARAM_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module tdp_ram_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int WRITE_MODE_A   = 0,
  parameter int WRITE_MODE_B   = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  output logic                    BUSY,
  input  logic                    WEN_A,
  input  logic                    REN_A,
  input  logic [DATA_WIDTH/8-1:0] BE_A,
  input  logic [ADDR_WIDTH-1:0]   ADDR_A,
  input  logic [DATA_WIDTH-1:0]   WDATA_A,
  output logic [DATA_WIDTH-1:0]   RDATA_A,
  output logic                    RVALID_A,
  input  logic                    WEN_B,
  input  logic                    REN_B,
  input  logic [DATA_WIDTH/8-1:0] BE_B,
  input  logic [ADDR_WIDTH-1:0]   ADDR_B,
  input  logic [DATA_WIDTH-1:0]   WDATA_B,
  output logic [DATA_WIDTH-1:0]   RDATA_B,
  output logic                    RVALID_B,
  output logic                    COLLISION
);
  localparam int NB        = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int MODE_WF   = 0;
  localparam int MODE_NC   = 2;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic                  rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic                  coll_q, coll_d;
  logic                  ready, wr_a, wr_b, rd_a, rd_b;
  logic [DATA_WIDTH-1:0] old_a, old_b;

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                  input logic [DATA_WIDTH-1:0] new_w,
                                                  input logic [NB-1:0]         be);
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++)
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  assign ready = (state_q == READY);
  assign BUSY  = (state_q == CLEAR);
  assign wr_a  = ready & WEN_A;
  assign wr_b  = ready & WEN_B;
  assign rd_a  = ready & REN_A;
  assign rd_b  = ready & REN_B;
  assign old_a = mem[ADDR_A];
  assign old_b = mem[ADDR_B];

  // The extra counter bit flags the terminal count without wrapping back to address 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d[ADDR_WIDTH]) state_d = READY;
    end
  end

  always_comb begin
    rvalid_a_d = rd_a & ~((WRITE_MODE_A == MODE_NC) & wr_a);
    rdata_a_d  = rdata_a_q;
    if (rvalid_a_d)
      rdata_a_d = ((WRITE_MODE_A == MODE_WF) && wr_a) ? merge(old_a, WDATA_A, BE_A) : old_a;
    rvalid_b_d = rd_b & ~((WRITE_MODE_B == MODE_NC) & wr_b);
    rdata_b_d  = rdata_b_q;
    if (rvalid_b_d)
      rdata_b_d = ((WRITE_MODE_B == MODE_WF) && wr_b) ? merge(old_b, WDATA_B, BE_B) : old_b;
    coll_d = ready & (ADDR_A == ADDR_B) & (WEN_A | WEN_B) & (WEN_A | REN_A) & (WEN_B | REN_B);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt_q      <= '0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      coll_q     <= coll_d;
    end
  end

  // Port A is written after port B so A wins on bytes both ports enable.
  always_ff @(posedge CLK) begin
    if (state_q == CLEAR) begin
      mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
    end else begin
      if (wr_b)
        for (int i = 0; i < NB; i++)
          if (BE_B[i]) mem[ADDR_B][8*i +: 8] <= WDATA_B[8*i +: 8];
      if (wr_a)
        for (int i = 0; i < NB; i++)
          if (BE_A[i]) mem[ADDR_A][8*i +: 8] <= WDATA_A[8*i +: 8];
    end
  end

`ifdef TDP_RAM_PARAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] rdata_a_q2, rdata_b_q2;
  logic                  rvalid_a_q2, rvalid_b_q2, coll_q2;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rdata_a_q2  <= '0;
      rdata_b_q2  <= '0;
      rvalid_a_q2 <= 1'b0;
      rvalid_b_q2 <= 1'b0;
      coll_q2     <= 1'b0;
    end else begin
      rdata_a_q2  <= rdata_a_q;
      rdata_b_q2  <= rdata_b_q;
      rvalid_a_q2 <= rvalid_a_q;
      rvalid_b_q2 <= rvalid_b_q;
      coll_q2     <= coll_q;
    end
  end

  assign RDATA_A   = rdata_a_q2;
  assign RDATA_B   = rdata_b_q2;
  assign RVALID_A  = rvalid_a_q2;
  assign RVALID_B  = rvalid_b_q2;
  assign COLLISION = coll_q2;
`else
  assign RDATA_A   = rdata_a_q;
  assign RDATA_B   = rdata_b_q;
  assign RVALID_A  = rvalid_a_q;
  assign RVALID_B  = rvalid_b_q;
  assign COLLISION = coll_q;
`endif

endmodule

// File: tb/tb_tdp_ram_param.sv
// Bench for tdp_ram_param: default instance checked against a shadow memory and scoreboard,
// plus a small READ_FIRST / NO_CHANGE instance without clear-on-reset.
module tb_tdp_ram_param;
  localparam int DW = 32;
  localparam int AW = 10;
`ifdef TDP_RAM_PARAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          busy, coll;
  logic          wen_a, ren_a, wen_b, ren_b, rvalid_a, rvalid_b;
  logic [3:0]    be_a, be_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b, rdata_a, rdata_b;

  logic          busy2, coll2;
  logic          wen_a2, ren_a2, wen_b2, ren_b2, rvalid_a2, rvalid_b2;
  logic [3:0]    be_a2, be_b2, addr_a2, addr_b2;
  logic [DW-1:0] wdata_a2, wdata_b2, rdata_a2, rdata_b2;

  tdp_ram_param dut (
    .CLK(clk), .RESET_N(rst_n), .BUSY(busy),
    .WEN_A(wen_a), .REN_A(ren_a), .BE_A(be_a), .ADDR_A(addr_a), .WDATA_A(wdata_a),
    .RDATA_A(rdata_a), .RVALID_A(rvalid_a),
    .WEN_B(wen_b), .REN_B(ren_b), .BE_B(be_b), .ADDR_B(addr_b), .WDATA_B(wdata_b),
    .RDATA_B(rdata_b), .RVALID_B(rvalid_b), .COLLISION(coll)
  );

  tdp_ram_param #(.ADDR_WIDTH(4), .WRITE_MODE_A(1), .WRITE_MODE_B(2), .CLEAR_ON_RESET(0)) dut2 (
    .CLK(clk), .RESET_N(rst_n), .BUSY(busy2),
    .WEN_A(wen_a2), .REN_A(ren_a2), .BE_A(be_a2), .ADDR_A(addr_a2), .WDATA_A(wdata_a2),
    .RDATA_A(rdata_a2), .RVALID_A(rvalid_a2),
    .WEN_B(wen_b2), .REN_B(ren_b2), .BE_B(be_b2), .ADDR_B(addr_b2), .WDATA_B(wdata_b2),
    .RDATA_B(rdata_b2), .RVALID_B(rvalid_b2), .COLLISION(coll2)
  );

  typedef struct { logic [DW-1:0] d; int due; } exp_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  logic          mon_en  = 1'b0;
  exp_t          qa[$], qb[$];
  int            cq[$];
  exp_t          me;
  logic          coll_exp;
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  logic [DW-1:0] model [0:(1<<AW)-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mrg(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                        input logic [3:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic idle();
    wen_a = 0; ren_a = 0; be_a = '0; addr_a = '0; wdata_a = '0;
    wen_b = 0; ren_b = 0; be_b = '0; addr_b = '0; wdata_b = '0;
  endtask

  task automatic idle2();
    wen_a2 = 0; ren_a2 = 0; be_a2 = '0; addr_a2 = '0; wdata_a2 = '0;
    wen_b2 = 0; ren_b2 = 0; be_b2 = '0; addr_b2 = '0; wdata_b2 = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < (1 << AW); i++) model[i] = '0;
    qa.delete(); qb.delete(); cq.delete();
  endtask

  // One cycle on the default instance; expectations derived from the shadow memory.
  task automatic op(input logic wa, input logic ra, input logic [AW-1:0] aa,
                    input logic [DW-1:0] da, input logic [3:0] ba,
                    input logic wb, input logic rb, input logic [AW-1:0] ab,
                    input logic [DW-1:0] db, input logic [3:0] bb);
    exp_t e;
    if (ra) begin
      e.d = wa ? mrg(model[aa], da, ba) : model[aa];
      e.due = cyc + LAT; qa.push_back(e);
    end
    if (rb) begin
      e.d = wb ? mrg(model[ab], db, bb) : model[ab];
      e.due = cyc + LAT; qb.push_back(e);
    end
    if (aa == ab && (wa || wb) && (wa || ra) && (wb || rb)) cq.push_back(cyc + LAT);
    if (wb) model[ab] = mrg(model[ab], db, bb);
    if (wa) model[aa] = mrg(model[aa], da, ba);
    wen_a = wa; ren_a = ra; addr_a = aa; wdata_a = da; be_a = ba;
    wen_b = wb; ren_b = rb; addr_b = ab; wdata_b = db; be_b = bb;
    @(posedge clk); #1;
    idle();
  endtask

  // One access on the mode instance, returning at the negedge where its result is visible.
  task automatic d2_op(input logic wa, input logic ra, input logic [3:0] aa, input logic [DW-1:0] da,
                       input logic wb, input logic rb, input logic [3:0] ab, input logic [DW-1:0] db);
    wen_a2 = wa; ren_a2 = ra; addr_a2 = aa; wdata_a2 = da; be_a2 = '1;
    wen_b2 = wb; ren_b2 = rb; addr_b2 = ab; wdata_b2 = db; be_b2 = '1;
    @(posedge clk); #1;
    idle2();
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
  endtask

  // Counts BUSY cycles (bounded); pokes illegal traffic that the clear must ignore.
  task automatic wait_clear(input string tag, input int stop_at, output int n);
    n = 0;
    while (n < 5000) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 10) begin
        wen_a = 1; ren_a = 1; addr_a = '1; wdata_a = '1; be_a = '1;
        ren_b = 1; addr_b = '1;
      end
      if (n == 200) begin
        check({tag, "_rvalid"}, {rvalid_a, rvalid_b}, 0);
        check({tag, "_coll"}, coll, 0);
      end
      if (n == 1000) idle();
      if (n == stop_at) break;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rvalid_a) begin
        if (qa.size() == 0) check("rvalid_a_unexpected", 1, 0);
        else begin
          me = qa.pop_front();
          check("rdata_a", rdata_a, me.d);
          check("latency_a", cyc, me.due);
          last_a = me.d;
        end
      end else if (qa.size() != 0 && cyc >= qa[0].due) begin
        check("rvalid_a_missing", 0, 1);
        me = qa.pop_front();
      end
      if (rvalid_b) begin
        if (qb.size() == 0) check("rvalid_b_unexpected", 1, 0);
        else begin
          me = qb.pop_front();
          check("rdata_b", rdata_b, me.d);
          check("latency_b", cyc, me.due);
          last_b = me.d;
        end
      end else if (qb.size() != 0 && cyc >= qb[0].due) begin
        check("rvalid_b_missing", 0, 1);
        me = qb.pop_front();
      end
      coll_exp = (cq.size() != 0 && cq[0] == cyc);
      if (coll_exp) cq.pop_front();
      if (coll || coll_exp) check("collision", coll, coll_exp);
    end
  end

  task automatic drain_check(input string tag);
    repeat (LAT + 3) @(posedge clk);
    #1;
    check({tag, "_qa_empty"}, qa.size(), 0);
    check({tag, "_qb_empty"}, qb.size(), 0);
    check({tag, "_coll_q_empty"}, cq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    idle(); idle2(); clear_model();
    #23;
    check("rst_busy", busy, 1);
    check("rst_rdata", {rdata_a, rdata_b}, 0);
    check("rst_rvalid", {rvalid_a, rvalid_b}, 0);
    check("rst_coll", coll, 0);
    check("rst_busy2", busy2, 0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clear("clear1", 0, n);
    check("clear1_len", n, 1024);
    check("clear1_busy_low", busy, 0);

    @(posedge clk); #1;
    mon_en = 1'b1;
    op(0, 1, 10'h3FF, 0, 0, 0, 1, 10'h3FF, 0, 0);
    op(1, 0, 10'h010, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 0, 0);
    op(1, 0, 10'h010, 32'h11223344, 4'b0101, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0, 1, 10'h010, 0, 0);
    op(1, 0, 10'h020, 32'hAAAAAAAA, 4'hF, 0, 0, 0, 0, 0);
    op(1, 1, 10'h020, 32'h55555555, 4'hF, 0, 1, 10'h020, 0, 0);
    op(1, 0, 10'h030, 32'h000000FF, 4'b0001, 1, 0, 10'h030, 32'h0000FF00, 4'b0011);
    op(0, 1, 10'h030, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'(10'h40 + $urandom_range(0, 7)),
         $urandom, 4'($urandom_range(0, 15)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'(10'h40 + $urandom_range(0, 7)),
         $urandom, 4'($urandom_range(0, 15)));
    op(0, 1, 10'h010, 0, 0, 0, 1, 10'h030, 0, 0);
    drain_check("traffic");
    @(negedge clk);
    check("hold_rdata_a", rdata_a, last_a);
    check("hold_rdata_b", rdata_b, last_b);
    check("hold_rvalid", {rvalid_a, rvalid_b}, 0);

    @(posedge clk); #1;
    d2_op(1, 0, 4'd2, 32'hAAAAAAAA, 1, 0, 4'd3, 32'hAAAAAAAA);
    @(posedge clk); #1;
    d2_op(1, 1, 4'd2, 32'h55555555, 0, 1, 4'd3, 0);
    check("rf_rvalid_a", rvalid_a2, 1);
    check("rf_rdata_a", rdata_a2, 32'hAAAAAAAA);
    check("nc_prior_read_b", rdata_b2, 32'hAAAAAAAA);
    @(posedge clk); #1;
    d2_op(0, 1, 4'd2, 0, 1, 1, 4'd3, 32'h55555555);
    check("rf_written_a", rdata_a2, 32'h55555555);
    check("nc_rvalid_b", rvalid_b2, 0);
    check("nc_hold_b", rdata_b2, 32'hAAAAAAAA);
    @(posedge clk); #1;
    d2_op(0, 0, 0, 0, 0, 1, 4'd3, 0);
    check("nc_written_rvalid_b", rvalid_b2, 1);
    check("nc_written_b", rdata_b2, 32'h55555555);

    @(posedge clk); #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    idle(); clear_model();
    #1;
    check("rst2_rdata", {rdata_a, rdata_b}, 0);
    check("rst2_busy", busy, 1);
    check("rst2_rdata2", rdata_a2, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clear("clear2", 500, n);
    check("clear2_reached_500", n, 500);
    rst_n = 1'b0;
    idle();
    #1;
    check("midclear_rst_busy", busy, 1);
    check("midclear_rst_rvalid", {rvalid_a, rvalid_b, coll}, 0);
    check("midclear_rst_rdata", {rdata_a, rdata_b}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clear("clear3", 0, n);
    check("clear3_len", n, 1024);

    @(posedge clk); #1;
    mon_en = 1'b1;
    op(0, 1, 10'h010, 0, 0, 0, 1, 10'h030, 0, 0);
    op(0, 1, 10'h3FF, 0, 0, 0, 1, 10'h020, 0, 0);
    drain_check("after_clear");
    d2_op(0, 1, 4'd2, 0, 0, 0, 0, 0);
    check("noclear_keeps_mem", rdata_a2, 32'h55555555);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tdp_ram_param.md
TDP_RAM_PARAM -- requirements
Module: tdp_ram_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8 and in the range 8..128.
REQ-002 Parameter ADDR_WIDTH, default 10: address width; depth is 2**ADDR_WIDTH words; range 4..15.
REQ-003 Parameter WRITE_MODE_A, default 0: port A same-port read/write mode (0 WRITE_FIRST, 1 READ_FIRST, 2 NO_CHANGE).
REQ-004 Parameter WRITE_MODE_B, default 0: port B mode, same encoding as WRITE_MODE_A.
REQ-005 Parameter CLEAR_ON_RESET, default 1: when 1, the memory is zero-filled after reset.
REQ-006 Ports:
- CLK  in  1  single clock; both ports are sampled on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- BUSY  out  1  clear sequence in progress.
- WEN_A, REN_A  in  1  port A write enable, read enable.
- BE_A  in  DATA_WIDTH/8  port A byte-write enables.
- ADDR_A  in  ADDR_WIDTH  port A word address.
- WDATA_A  in  DATA_WIDTH  port A write data.
- RDATA_A  out  DATA_WIDTH  port A read data.
- RVALID_A  out  1  RDATA_A updated this cycle.
- WEN_B, REN_B, BE_B, ADDR_B, WDATA_B, RDATA_B, RVALID_B: port B, identical to the port A set.
- COLLISION  out  1  one-cycle cross-port collision pulse.

Function
REQ-007 BE_x[i] SHALL gate WDATA_x[8i+7:8i]; a byte with BE_x[i]=0 SHALL be left unchanged.
REQ-008 A read SHALL return data on RDATA_x with RVALID_x=1 exactly 1 cycle after REN_x is sampled high.
REQ-009 With no accepted read, RDATA_x SHALL hold its last value and RVALID_x SHALL be 0.
REQ-010 Same-port REN and WEN in one cycle:
- WRITE_FIRST: RDATA SHALL return the post-write word, with the new bytes merged per BE.
- READ_FIRST: RDATA SHALL return the pre-write word.
- NO_CHANGE: the write SHALL complete, RDATA SHALL hold, and RVALID SHALL stay 0.
REQ-011 Cross-port, same address, same cycle, at least one write: COLLISION SHALL be 1 in the following cycle.
REQ-012 Both ports writing the same address: port A data SHALL win on bytes enabled by both ports; bytes enabled only by port B SHALL take WDATA_B.
REQ-013 A read on one port of an address being written by the other port in the same cycle SHALL return the pre-write word.
REQ-014 FSM states: CLEAR and READY.
- The reset value is CLEAR if CLEAR_ON_RESET=1, otherwise READY.
- CLEAR SHALL write zero to address counter value 0, 1, ..., 2**ADDR_WIDTH-1, one word per cycle.
- After the last address, CLEAR SHALL go to READY.
- READY is terminal until the next reset.
REQ-015 In CLEAR: BUSY=1, all port WEN/REN SHALL be ignored, and RVALID and COLLISION SHALL be 0; in READY: BUSY=0.
REQ-016 The clear takes exactly 2**ADDR_WIDTH cycles from the first rising CLK edge after RESET_N deasserts.
REQ-017 The address counter SHALL be ADDR_WIDTH+1 bits so that the terminal count is detected without wrap-around.

Reset
REQ-018 When RESET_N=0, the block SHALL immediately set:
- RDATA_A = RDATA_B = 0;
- RVALID_A = RVALID_B = 0;
- COLLISION = 0;
- clear counter = 0;
- BUSY = CLEAR_ON_RESET.
REQ-019 Reset asserted mid-clear or mid-access SHALL abort the operation; the clear SHALL restart from address 0 after deassertion.
REQ-020 If CLEAR_ON_RESET=0, reset SHALL NOT modify memory contents; simulation initial contents are zero.

Configuration
REQ-021 Macro TDP_RAM_PARAM_OUT_REG_EN:
- Defined: an output register stage SHALL be added to each port, giving read latency 2, with RVALID_x and COLLISION delayed to match; the extra stage SHALL also reset to 0.
- Undefined: read latency is 1 as in REQ-008.

Verification
REQ-022 Defaults, reset released at t0 -> BUSY=1 for 1024 cycles, then 0; a read of address 0x3FF then returns 0x00000000.
REQ-023 A writes 0xDEADBEEF at 0x010 with BE_A=4'b1111, then A writes 0x11223344 at 0x010 with BE_A=4'b0101; B then reads 0x010 -> RDATA_B=0xDE22BE44 and RVALID_B=1 one cycle later.
REQ-024 Per mode, address 0x020 holds 0xAAAAAAAA; port A reads and writes 0x55555555 in the same cycle:
- WRITE_FIRST -> 0x55555555;
- READ_FIRST -> 0xAAAAAAAA;
- NO_CHANGE -> RDATA_A holds and RVALID_A=0.
REQ-025 Same cycle at 0x030: A writes 0x000000FF with BE=4'b0001 while B writes 0x0000FF00 with BE=4'b0011 -> COLLISION=1 next cycle; a subsequent read returns 0x0000FFFF.
REQ-026 RESET_N pulsed low at clear cycle 500 -> outputs go to 0 immediately; after release, BUSY=1 for a full 1024 cycles.
REQ-027 With TDP_RAM_PARAM_OUT_REG_EN defined, repeat REQ-023 -> the same data arrives 2 cycles after REN.
